reset_release_seq: RTL and testbench

// - Driver side of the async-reset pin on DFFRE-style primitives: produces the active-low

---
 rtl/reset_release_seq.sv | 104 ++++++++++
 tb/tb_reset_release_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reset_release_seq.sv
// Reset release sequencer: async assert, synchronised + stretched release, delayed enable.
// Optional soft reset input SR enabled by RESET_RELEASE_SEQ_SOFT_RESET_EN.
module reset_release_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int EN_DELAY    = 1
) (
  input  logic       C,
  input  logic       R,
`ifdef RESET_RELEASE_SEQ_SOFT_RESET_EN
  input  logic       SR,
`endif
  output logic       R_OUT,
  output logic       E_OUT,
  output logic       BUSY,
  output logic [1:0] ST
);

  typedef enum logic [1:0] {
    S_SYNC = 2'b00,
    S_HOLD = 2'b01,
    S_REL  = 2'b10,
    S_RUN  = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  state_e                 rel_next, hold_next;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             hcnt_q, hcnt_d;
  logic [3:0]             ecnt_q, ecnt_d;
  logic                   r_out_q, r_out_d;
  logic                   e_out_q, e_out_d;
  logic                   sync_done;
  logic                   hold_last;
  logic                   rel_last;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

  // Leave SYNC on the edge where the last chain stage captures 1.
  assign sync_done = sync_q[SYNC_STAGES-2] | sync_q[SYNC_STAGES-1];

  assign hold_last = ({1'b0, hcnt_q} + 9'd1) >= 9'(HOLD_CYCLES);
  assign rel_last  = ({1'b0, ecnt_q} + 5'd1) >= 5'(EN_DELAY);

  assign rel_next  = (EN_DELAY == 0) ? S_RUN : S_REL;
  assign hold_next = (HOLD_CYCLES == 0) ? rel_next : S_HOLD;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      S_SYNC: begin
        if (sync_done) state_d = hold_next;
      end
      S_HOLD: begin
        if (hold_last) state_d = rel_next;
        else           hcnt_d  = hcnt_q + 8'd1;
      end
      S_REL: begin
        if (rel_last) state_d = S_RUN;
        else          ecnt_d  = ecnt_q + 4'd1;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_SYNC;
    endcase
`ifdef RESET_RELEASE_SEQ_SOFT_RESET_EN
    // Soft reset re-enters HOLD; the chain is already synchronised.
    if (SR && (state_q != S_SYNC)) begin
      state_d = S_HOLD;
      hcnt_d  = '0;
      ecnt_d  = '0;
    end
`endif
    r_out_d = (state_d == S_REL) || (state_d == S_RUN);
    e_out_d = (state_d == S_RUN);
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state_q <= S_SYNC;
      sync_q  <= '0;
      hcnt_q  <= '0;
      ecnt_q  <= '0;
      r_out_q <= 1'b0;
      e_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hcnt_q  <= hcnt_d;
      ecnt_q  <= ecnt_d;
      r_out_q <= r_out_d;
      e_out_q <= e_out_d;
    end
  end

  assign R_OUT = r_out_q;
  assign E_OUT = e_out_q;
  assign BUSY  = (state_q != S_RUN);
  assign ST    = state_q;

endmodule

// File: tb/tb_reset_release_seq.sv
// Directed bench for reset_release_seq: default build and a
// SYNC_STAGES=3/HOLD=0/EN_DELAY=0 instance sharing clock and reset.
`timescale 1ns/100ps
module tb_reset_release_seq;

  logic       C = 1'b0;
  logic       R = 1'b0;
  logic       SR = 1'b0;
  logic       R_OUT, E_OUT, BUSY;
  logic [1:0] ST;
  logic       R_OUT2, E_OUT2, BUSY2;
  logic [1:0] ST2;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  always #5 C = ~C;

  reset_release_seq dut (
    .C(C),
    .R(R),
`ifdef RESET_RELEASE_SEQ_SOFT_RESET_EN
    .SR(SR),
`endif
    .R_OUT(R_OUT),
    .E_OUT(E_OUT),
    .BUSY(BUSY),
    .ST(ST)
  );

  logic SR2 = 1'b0;

  reset_release_seq #(
    .SYNC_STAGES(3),
    .HOLD_CYCLES(0),
    .EN_DELAY(0)
  ) dut2 (
    .C(C),
    .R(R),
`ifdef RESET_RELEASE_SEQ_SOFT_RESET_EN
    .SR(SR2),
`endif
    .R_OUT(R_OUT2),
    .E_OUT(E_OUT2),
    .BUSY(BUSY2),
    .ST(ST2)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h",
             tag, edge_n, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_st(input int e);
    if (e < 2)       return 2'b00;
    else if (e < 6)  return 2'b01;
    else if (e == 6) return 2'b10;
    else             return 2'b11;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rout"}, {7'd0, R_OUT}, 8'd0);
    chk({tag, "_eout"}, {7'd0, E_OUT}, 8'd0);
    chk({tag, "_busy"}, {7'd0, BUSY}, 8'd1);
    chk({tag, "_st"}, {6'd0, ST}, 8'd0);
    chk({tag, "_rout2"}, {7'd0, R_OUT2}, 8'd0);
    chk({tag, "_st2"}, {6'd0, ST2}, 8'd0);
  endtask

  // Edges counted from a release of R between clock edges.
  task automatic run_edges(input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge C);
      @(negedge C);
      edge_n = e;
      chk("st", {6'd0, ST}, {6'd0, exp_st(e)});
      chk("rout", {7'd0, R_OUT}, {7'd0, (e >= 6)});
      chk("eout", {7'd0, E_OUT}, {7'd0, (e >= 7)});
      chk("busy", {7'd0, BUSY}, {7'd0, (e < 7)});
      chk("st2", {6'd0, ST2}, (e >= 3) ? 8'd3 : 8'd0);
      chk("rout2", {7'd0, R_OUT2}, {7'd0, (e >= 3)});
      chk("eout2", {7'd0, E_OUT2}, {7'd0, (e >= 3)});
      chk("busy2", {7'd0, BUSY2}, {7'd0, (e < 3)});
    end
  endtask

  initial begin
    // Power-up / reset held for three cycles
    repeat (3) @(posedge C);
    @(negedge C);
    chk_reset("reset");

    // Release mid-period and follow the full sequence
    R = 1'b1;
    run_edges(7);

    // Short glitch in RUN clears everything without a clock
    repeat (3) @(posedge C);
    @(negedge C);
    #2 R = 1'b0;
    #0.1 chk_reset("glitch");
    #0.2 R = 1'b1;
    #0.1 chk_reset("post_glitch");
    run_edges(7);

    // Abort during HOLD with the hold counter at 2
    @(negedge C);
    R = 1'b0;
    #1 R = 1'b1;
    run_edges(4);
    #1 R = 1'b0;
    #0.5 chk_reset("hold_abort");
    R = 1'b1;
    run_edges(7);

`ifdef RESET_RELEASE_SEQ_SOFT_RESET_EN
    // SR at edge 1 (SYNC) ignored; SR at edges 20-22 restarts from HOLD
    @(negedge C);
    R = 1'b0;
    #1;
    SR = 1'b1;
    R  = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      logic [1:0] est;
      @(posedge C);
      @(negedge C);
      edge_n = e;
      SR = (e >= 19) && (e <= 21);
      if (e < 2)       est = 2'b00;
      else if (e < 6)  est = 2'b01;
      else if (e == 6) est = 2'b10;
      else if (e < 20) est = 2'b11;
      else if (e < 26) est = 2'b01;
      else if (e == 26) est = 2'b10;
      else             est = 2'b11;
      chk("sr_st", {6'd0, ST}, {6'd0, est});
      chk("sr_rout", {7'd0, R_OUT},
          {7'd0, ((e >= 6) && (e < 20)) || (e >= 26)});
      chk("sr_eout", {7'd0, E_OUT},
          {7'd0, ((e >= 7) && (e < 20)) || (e >= 27)});
    end
    SR = 1'b0;
`endif

    // Random reset activity: enable never without released reset
    edge_n = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge C);
      R = ($urandom_range(0, 7) != 0);
      #1;
      chk("inv", {6'd0, E_OUT, R_OUT}, {6'd0, E_OUT & R_OUT, R_OUT});
      chk("inv2", {6'd0, E_OUT2, R_OUT2}, {6'd0, E_OUT2 & R_OUT2, R_OUT2});
      @(posedge C);
      #1;
      chk("inv_p", {6'd0, E_OUT, R_OUT}, {6'd0, E_OUT & R_OUT, R_OUT});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
